// File: rtl/nibble_arbiter_pkg.sv
// Shared definitions for the nibble arbiter.
//   NIB_W   : width of one data nibble
//   IDW     : width of a requester index (cur_id, rr pointer); covers up to 8 requesters
//   state_t : arbiter FSM state codes
package nibble_arbiter_pkg;

  localparam int NIB_W = 4;
  localparam int IDW   = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans requesters starting just after the last served one (ptr+1, ptr+2, ...
// modulo NREQ) and returns the first one with its request bit set.
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  IDW   index of the most recently served requester
//   winner out IDW   selected requester (0 when none requests)
//   any    out 1     at least one request is pending
module nibble_arbiter_rr_pick
  import nibble_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  int   idx;
  logic hit;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    hit    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      // ptr < NREQ and k <= NREQ, so one subtraction is enough for the modulo
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      hit = |(req & (NREQ'(1) << idx));
      if (!any && hit) begin
        winner = IDW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nibble_arbiter.sv
// Round-robin scheduler that shares one nibble serializer between NREQ
// requesters. The winner's nibble is latched and presented to the serializer
// until it acknowledges; the requester then gets a one-cycle grant. If no
// acknowledge arrives within TIMEOUT cycles the transfer is abandoned and a
// one-cycle timeout_err is raised instead. Every output is a register.
// Ports:
//   sclk        in   1       clock, all logic on posedge
//   rst         in   1       synchronous active-low reset
//   req         in   NREQ    level request per requester
//   req_data    in   4*NREQ  nibble per requester, requester i on [4i+3:4i]
//   gnt         out  NREQ    one-hot 1-cycle pulse: nibble consumed
//   ser_data    out  4       nibble to serializer, stable while ser_valid
//   ser_valid   out  1       nibble presented, awaiting ack
//   ser_ack     in   1       serializer ack, rising edge = nibble consumed
//   cur_id      out  3       requester being served (meaningful while busy)
//   busy        out  1       high while waiting for ack and during the gap
//   timeout_err out  1       1-cycle pulse: transfer abandoned
//
// Handshake: ser_valid rises with ser_data already stable and both stay
// frozen until the serializer produces a rising edge on ser_ack (a level
// that is already high does not count) or the timeout expires. ser_valid
// falls on the edge that consumes the ack, and is then held low for at least
// the one GAP cycle so the serializer always sees a low phase between nibbles.
module nibble_arbiter
  import nibble_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NIB_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NIB_W-1:0]      ser_data,
  output logic                  ser_valid,
  input  logic                  ser_ack,
  output logic [IDW-1:0]        cur_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state, state_n;
  logic [IDW-1:0]   ptr, ptr_n;
  logic [TW-1:0]    timer, timer_n;
  logic             ack_d;
  logic             ack_rise;

  logic [NREQ-1:0]  gnt_n;
  logic [NIB_W-1:0] ser_data_n;
  logic             ser_valid_n;
  logic [IDW-1:0]   cur_id_n;
  logic             busy_n;
  logic             timeout_err_n;

  logic [IDW-1:0]   pick_id;
  logic             pick_any;

  nibble_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_id),
    .any    (pick_any)
  );

  // Only a fresh low-to-high transition completes a transfer.
  assign ack_rise = ser_ack & ~ack_d;

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    timer_n       = timer;
    ser_data_n    = ser_data;
    cur_id_n      = cur_id;
    ser_valid_n   = ser_valid;
    busy_n        = busy;
    gnt_n         = '0;
    timeout_err_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          ser_data_n  = NIB_W'(req_data >> (NIB_W * int'(pick_id)));
          cur_id_n    = pick_id;
          ser_valid_n = 1'b1;
          busy_n      = 1'b1;
          timer_n     = '0;
          state_n     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        timer_n = timer + TW'(1);
        // Ack is checked first so a rise on the last allowed cycle still wins.
        if (ack_rise) begin
          gnt_n       = NREQ'(1) << cur_id;
          ser_valid_n = 1'b0;
          ptr_n       = cur_id;
          state_n     = ST_GAP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_err_n = 1'b1;
          ser_valid_n   = 1'b0;
          ptr_n         = cur_id;
          state_n       = ST_GAP;
        end
      end
      ST_GAP: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ptr         <= IDW'(NREQ - 1);
      timer       <= '0;
      ack_d       <= 1'b0;
      gnt         <= '0;
      ser_data    <= '0;
      ser_valid   <= 1'b0;
      cur_id      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      timer       <= timer_n;
      ack_d       <= ser_ack;
      gnt         <= gnt_n;
      ser_data    <= ser_data_n;
      ser_valid   <= ser_valid_n;
      cur_id      <= cur_id_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
    end
  end

endmodule

// File: tb/tb_nibble_arbiter.sv
// Self-checking bench for nibble_arbiter: directed scenarios followed by a
// randomized run, all checked cycle by cycle against a transaction-style
// reference model.
module tb_nibble_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic                sclk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [4*NREQ-1:0]   req_data = '0;
  logic                ser_ack = 1'b0;
  logic [NREQ-1:0]     gnt;
  logic [3:0]          ser_data;
  logic                ser_valid;
  logic [2:0]          cur_id;
  logic                busy;
  logic                timeout_err;

  always #5 sclk = ~sclk;

  nibble_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .ser_data    (ser_data),
    .ser_valid   (ser_valid),
    .ser_ack     (ser_ack),
    .cur_id      (cur_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = free, 1 = transfer outstanding, 2 = mandatory pause
  int              m_phase;
  int              m_age;      // completed waiting cycles of current transfer
  int              m_last;     // last requester served
  int              m_id;
  logic            m_ack_prev;
  logic [3:0]      m_nib;
  logic            m_valid, m_busy, m_err, m_rst;
  logic [NREQ-1:0] m_gnt;
  logic [7:0]      exp_q[$];   // {id, nibble} of transfers the model started

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    m_gnt = '0;
    m_err = 1'b0;
    m_rst = 1'b0;
    if (!rst) begin
      m_phase = 0; m_age = 0; m_last = NREQ - 1; m_id = 0;
      m_ack_prev = 1'b0; m_nib = '0; m_valid = 1'b0; m_busy = 1'b0;
      m_rst = 1'b1;
      exp_q.delete();
      return;
    end
    if (m_phase == 0) begin
      w = pick(req, m_last);
      if (w >= 0) begin
        m_id = w;
        m_nib = req_data[4*w +: 4];
        m_valid = 1'b1; m_busy = 1'b1; m_age = 0; m_phase = 1;
        exp_q.push_back({4'(w), m_nib});
      end
    end else if (m_phase == 1) begin
      if (ser_ack && !m_ack_prev) begin
        m_gnt[m_id] = 1'b1;
        m_valid = 1'b0; m_last = m_id; m_phase = 2;
      end else if (m_age == TIMEOUT - 1) begin
        m_err = 1'b1;
        m_valid = 1'b0; m_last = m_id; m_phase = 2;
      end else begin
        m_age++;
      end
    end else begin
      m_phase = 0;
      m_busy = 1'b0;
    end
    m_ack_prev = ser_ack;
  endtask

  // ---------------- monitor state ----------------
  int         cyc = 0;
  logic       prev_valid = 1'b0;
  int         start_cyc = 0;
  int         err_cyc = 0;
  int         gnt_cnt = 0;
  int         err_cnt = 0;
  logic [3:0] obs[$];

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [7:0] e;
    @(posedge sclk);
    model_edge();
    #1;
    cyc++;
    check("ser_valid", ser_valid, m_valid);
    check("busy", busy, m_busy);
    check("gnt", gnt, m_gnt);
    check("timeout_err", timeout_err, m_err);
    if (m_valid || m_rst) begin
      check("ser_data", ser_data, m_nib);
    end
    if (m_busy || m_rst) begin
      check("cur_id", cur_id, 3'(m_id));
    end
    if (ser_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("start_id", cur_id, e[7:4]);
        check("start_nib", ser_data, e[3:0]);
      end
      obs.push_back(ser_data);
      start_cyc = cyc;
    end
    if (gnt != '0) gnt_cnt++;
    if (timeout_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    prev_valid = ser_valid;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!ser_valid && n < budget) begin
      step();
      n++;
    end
    if (!ser_valid) check("wait_valid_expired", 0, 1);
  endtask

  task automatic ack_after(input int d);
    repeat (d - 1) step();
    ser_ack = 1'b1;
    step();
    ser_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] rr_exp [5];

  initial begin
    rr_exp[0] = 4'h1; rr_exp[1] = 4'h2; rr_exp[2] = 4'h3;
    rr_exp[3] = 4'h4; rr_exp[4] = 4'h1;

    // 1: reset with all requesting
    req = 4'b1111;
    req_data = 16'hDCB5;
    do_reset(2);
    check("rst_valid", ser_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt, 0);
    check("rst_data", ser_data, 0);
    check("rst_err", timeout_err, 0);
    step();
    check("first_after_rst", ser_data, 4'h5);

    // 2: single requester, ack five cycles later
    req = '0;
    do_reset(2);
    req = 4'b0001;
    req_data = 16'h000A;
    gnt_cnt = 0;
    step();
    check("single_valid", ser_valid, 1);
    check("single_data", ser_data, 4'hA);
    ack_after(5);
    check("single_gnt", gnt, 4'b0001);
    check("single_valid_fall", ser_valid, 0);
    req = '0;
    repeat (4) step();
    check("single_gnt_count", gnt_cnt, 1);

    // 3: round-robin over all four
    do_reset(2);
    req = 4'b1111;
    req_data = 16'h4321;
    obs.delete();
    gnt_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      wait_valid(20);
      ack_after(3);
    end
    req = '0;
    repeat (3) step();
    check("rr_count", obs.size(), 5);
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      check("rr_order", obs[i], rr_exp[i]);
    end
    check("rr_gnt_count", gnt_cnt, 5);

    // 4: timeout with no ack, then fairness resumes at req0
    do_reset(2);
    req = 4'b0010;
    req_data = 16'h00E7;
    gnt_cnt = 0;
    err_cnt = 0;
    wait_valid(20);
    req = 4'b0011;
    for (int n = 0; n < 40 && err_cnt == 0; n++) step();
    if (err_cnt == 0) check("timeout_seen", 0, 1);
    check("timeout_delay", err_cyc - start_cyc, TIMEOUT);
    check("timeout_no_gnt", gnt_cnt, 0);
    wait_valid(20);
    check("after_timeout_id", cur_id, 0);
    check("after_timeout_data", ser_data, 4'h7);
    req = '0;
    ack_after(2);

    // 5a: ack already high before the transfer starts
    do_reset(2);
    ser_ack = 1'b1;
    repeat (2) step();
    req = 4'b0001;
    req_data = 16'h0003;
    gnt_cnt = 0;
    wait_valid(20);
    repeat (6) step();
    check("held_ack_no_gnt", gnt_cnt, 0);
    check("held_ack_valid", ser_valid, 1);
    ser_ack = 1'b0;
    step();
    ser_ack = 1'b1;
    step();
    check("fresh_rise_gnt", gnt, 4'b0001);
    ser_ack = 1'b0;
    req = '0;

    // 5b: ack rise on the timeout cycle
    do_reset(2);
    req = 4'b0001;
    err_cnt = 0;
    wait_valid(20);
    req = '0;
    ack_after(TIMEOUT);
    check("race_gnt", gnt, 4'b0001);
    check("race_no_err", timeout_err, 0);
    repeat (3) step();
    check("race_err_count", err_cnt, 0);

    // 6: reset in the middle of a transfer
    do_reset(2);
    req = 4'b1111;
    req_data = 16'h9876;
    wait_valid(20);
    ack_after(2);
    wait_valid(20);
    check("pre_rst_id", cur_id, 1);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("mid_rst_valid", ser_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_err", timeout_err, 0);
    rst = 1'b1;
    wait_valid(20);
    check("restart_id", cur_id, 0);
    check("restart_data", ser_data, 4'h6);
    req = '0;

    // Random traffic
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = NREQ'($urandom());
      if ($urandom_range(0, 3) == 0) req_data = 16'($urandom());
      if ($urandom_range(0, 3) == 0) ser_ack = ~ser_ack;
      rst = ($urandom_range(0, 299) != 0);
      step();
    end
    rst = 1'b1;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
